// File: rtl/ts4231_pkg.sv
// Shared constants and types for the TS4231 configuration-port responder.
package ts4231_pkg;

    localparam int CFG_W = 15;

    typedef enum logic [2:0] {
        IDLE,
        PRESENCE,
        CMD,
        WRITE_BITS,
        READ_BITS,
        WAIT_STOP
    } state_t;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

endpackage

// File: rtl/ts4231_line_sync.sv
// Synchronizer and edge detect for one pad line; TS4231_RESP_GLITCH_FILTER_EN adds
// a 3-sample majority filter after the synchronizer (rejects 1-clock pulses).
module ts4231_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       cond;
    logic       cond_q;

    always_ff @(posedge clock) begin
        if (!reset) sync <= 2'b00;
        else        sync <= {sync[0], din};
    end

`ifdef TS4231_RESP_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist <= 2'b00;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], sync[1]};
            filt <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
        end
    end

    assign cond = filt;
`else
    assign cond = sync[1];
`endif

    always_ff @(posedge clock) begin
        if (!reset) cond_q <= 1'b0;
        else        cond_q <= cond;
    end

    assign level = cond;
    assign rise  = cond & ~cond_q;
    assign fall  = ~cond & cond_q;

endmodule

// File: rtl/ts4231_cfg_responder.sv
// Sensor-side end of the TS4231 E/D configuration bus: presence pulse, write/read
// frames, stored config word. Optional glitch filter: TS4231_RESP_GLITCH_FILTER_EN.
module ts4231_cfg_responder
    import ts4231_pkg::*;
#(
    parameter logic [CFG_W-1:0] CFG_RESET       = '0,
    parameter int               PRESENCE_CYCLES = 100,
    parameter int               TIMEOUT_CYCLES  = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             e_in,
    input  logic             d_in,
    output logic             d_out,
    output logic             d_oe,
    input  logic             light_pulse,
    output logic [CFG_W-1:0] cfg_reg,
    output logic             cfg_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > PRESENCE_CYCLES) ? TIMEOUT_CYCLES : PRESENCE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int CNT_W   = $clog2(CFG_W);
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] PRES_LOAD = TMR_W'(PRESENCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CFG_W - 1);

    logic e_lvl, e_rise, e_fall, d_lvl, d_rise, d_fall;
    logic e_edge, start_cond, stop_cond, light_q, light_rise;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [CFG_W-1:0] shadow, shadow_nxt, cfg_nxt;
    logic             rd_frame, rd_nxt, stop_armed, armed_nxt;
    logic             d_out_nxt, d_oe_nxt, valid_nxt, err_nxt;

    ts4231_line_sync u_sync_e (.clock(clock), .reset(reset), .din(e_in),
                               .level(e_lvl), .rise(e_rise), .fall(e_fall));
    ts4231_line_sync u_sync_d (.clock(clock), .reset(reset), .din(d_in),
                               .level(d_lvl), .rise(d_rise), .fall(d_fall));

    // An E edge in the same cycle masks any D edge.
    assign e_edge     = e_rise | e_fall;
    assign start_cond = d_fall & e_lvl & ~e_edge;
    assign stop_cond  = d_rise & e_lvl & ~e_edge;
    assign light_rise = light_pulse & ~light_q;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = bit_cnt;
        tmr_nxt    = tmr;
        shadow_nxt = shadow;
        rd_nxt     = rd_frame;
        armed_nxt  = stop_armed;
        cfg_nxt    = cfg_reg;
        d_out_nxt  = d_out;
        d_oe_nxt   = 1'b0;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (light_rise) begin
                    state_nxt = PRESENCE;
                    tmr_nxt   = PRES_LOAD;
                    d_oe_nxt  = 1'b1;
                    d_out_nxt = 1'b1;
                end else if (start_cond) begin
                    state_nxt = CMD;
                    tmr_nxt   = TO_LOAD;
                end
            end
            PRESENCE: begin
                if (tmr == '0) begin
                    state_nxt = IDLE;
                    d_out_nxt = 1'b0;
                end else begin
                    tmr_nxt  = tmr - TMR_W'(1);
                    d_oe_nxt = 1'b1;
                end
            end
            default: begin
                if (start_cond) begin
                    err_nxt   = 1'b1;
                    state_nxt = CMD;
                    tmr_nxt   = TO_LOAD;
                end else if (e_edge) begin
                    tmr_nxt = TO_LOAD;
                    case (state)
                        CMD: if (e_rise) begin
                            rd_nxt    = (d_lvl == CMD_READ);
                            cnt_nxt   = CNT_LOAD;
                            state_nxt = (d_lvl == CMD_READ) ? READ_BITS : WRITE_BITS;
                        end
                        WRITE_BITS: if (e_rise) begin
                            shadow_nxt = {shadow[CFG_W-2:0], d_lvl};
                            if (bit_cnt == '0) begin
                                state_nxt = WAIT_STOP;
                                armed_nxt = 1'b0;
                            end else begin
                                cnt_nxt = bit_cnt - CNT_W'(1);
                            end
                        end
                        READ_BITS: begin
                            d_oe_nxt = d_oe;
                            if (e_fall) begin
                                d_oe_nxt  = 1'b1;
                                d_out_nxt = cfg_reg[bit_cnt];
                            end else if (bit_cnt == '0) begin
                                d_oe_nxt  = 1'b0;
                                state_nxt = WAIT_STOP;
                                armed_nxt = 1'b0;
                            end else begin
                                cnt_nxt = bit_cnt - CNT_W'(1);
                            end
                        end
                        // The first E rise after the last bit is the master's stop setup clock.
                        WAIT_STOP: if (e_rise) begin
                            if (!stop_armed) begin
                                armed_nxt = 1'b1;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                        default: ;
                    endcase
                end else if (stop_cond) begin
                    state_nxt = IDLE;
                    if (state == WAIT_STOP) begin
                        if (!rd_frame) begin
                            cfg_nxt   = shadow;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (tmr == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                    if (state == READ_BITS) d_oe_nxt = d_oe;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tmr        <= '0;
            shadow     <= '0;
            rd_frame   <= 1'b0;
            stop_armed <= 1'b0;
            cfg_reg    <= CFG_RESET;
            d_out      <= 1'b0;
            d_oe       <= 1'b0;
            cfg_valid  <= 1'b0;
            frame_err  <= 1'b0;
            light_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            tmr        <= tmr_nxt;
            shadow     <= shadow_nxt;
            rd_frame   <= rd_nxt;
            stop_armed <= armed_nxt;
            cfg_reg    <= cfg_nxt;
            d_out      <= d_out_nxt;
            d_oe       <= d_oe_nxt;
            cfg_valid  <= valid_nxt;
            frame_err  <= err_nxt;
            light_q    <= light_pulse;
        end
    end

endmodule
